// File: rtl/sequence_player.sv
// sequence_player
// Plays back a colour sequence held in a synchronous ROM. When start is
// accepted in IDLE, the player walks ROM addresses 0..round. Each step fetches
// a code, shows it on the LEDs for ON_TICKS cycles and then blanks them for
// OFF_TICKS cycles. After the last step it pulses done for one cycle so the
// game controller can hand over to player input.
//
// Ports:
//   clk       system clock, rising edge
//   R         synchronous reset, active-low
//   start     one-cycle play request, only looked at in IDLE
//   round     index of the last step to play, latched on acceptance
//   rom_addr  registered address to the sequence ROM
//   rom_data  ROM output, valid one cycle after rom_addr changes
//   led       registered LED drive, 0 = all off
//   busy      high while a sequence is in flight, including the done cycle
//   done      one-cycle pulse when the sequence has finished
module sequence_player #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int ON_TICKS  = 50,
  parameter int OFF_TICKS = 25
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W-1:0] round,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  // The tick counter runs from 0 to N-1, so the phase ends on the count N-1.
  localparam logic [9:0] ON_LAST  = 10'(ON_TICKS - 1);
  localparam logic [9:0] OFF_LAST = 10'(OFF_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_roundQ;
  logic [ADDR_W-1:0] r_romAddr;
  logic [DATA_W-1:0] r_led;
  logic [9:0]        r_tick;

  // Playback state machine. The ROM address register is also the step
  // index, so the ROM always sees the step being played. The last step is
  // detected by comparing that index with the latched round, which means the
  // index never runs past round and never wraps. The LEDs are written only
  // when SHOW is entered and when it is left, so they cannot glitch.
  always_ff @(posedge clk) begin
    if (!R) begin
      r_state   <= S_IDLE;
      r_roundQ  <= '0;
      r_romAddr <= '0;
      r_led     <= '0;
      r_tick    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_roundQ  <= round;
            r_romAddr <= '0;
            r_state   <= S_FETCH;
          end
        end
        // Address is stable this cycle; the ROM answers in the next one.
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_led   <= rom_data;
          r_tick  <= '0;
          r_state <= S_SHOW;
        end
        S_SHOW: begin
          if (r_tick == ON_LAST) begin
            r_led   <= '0;
            r_tick  <= '0;
            r_state <= S_GAP;
          end else begin
            r_tick <= r_tick + 10'd1;
          end
        end
        S_GAP: begin
          if (r_tick == OFF_LAST) begin
            r_tick <= '0;
            if (r_romAddr == r_roundQ) begin
              r_state <= S_FIN;
            end else begin
              r_romAddr <= r_romAddr + ADDR_ONE;
              r_state   <= S_FETCH;
            end
          end else begin
            r_tick <= r_tick + 10'd1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr = r_romAddr;
  assign led      = r_led;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player
// Self-checking bench for sequence_player with ON_TICKS=3 and OFF_TICKS=2,
// which gives 7 cycles per step. A behavioural ROM drives rom_data. The
// expected outputs for each cycle come from the playback schedule: cycle t
// after acceptance falls in step t/7 at phase t%7. The LEDs show the ROM
// code during phases 2..4, and the done cycle falls at (round+1)*7.
module tb_sequence_player;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = 2 + ON + OFF;

  logic       clk = 1'b0;
  logic       R;
  logic       start;
  logic [3:0] round;
  logic [3:0] romAddr;
  logic [3:0] romData;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [3:0] rom [16];

  int compareCount = 0;
  int failCount    = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) romData <= rom[romAddr];

  sequence_player #(
    .ADDR_W(4), .DATA_W(4), .ON_TICKS(ON), .OFF_TICKS(OFF)
  ) dut (
    .clk(clk), .R(R), .start(start), .round(round),
    .rom_addr(romAddr), .rom_data(romData),
    .led(led), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ctx, input logic [3:0] expLed,
                          input logic [3:0] expAddr, input logic expBusy,
                          input logic expDone);
    checkOutput({ctx, " led"},  32'(led),     32'(expLed));
    checkOutput({ctx, " addr"}, 32'(romAddr), 32'(expAddr));
    checkOutput({ctx, " busy"}, 32'(busy),    32'(expBusy));
    checkOutput({ctx, " done"}, 32'(done),    32'(expDone));
  endtask

  // Starts a sequence with the given round, then checks every cycle through
  // the done cycle and the following IDLE cycle. The call leaves the bench
  // in that IDLE cycle, so a second call starts immediately after it.
  // abortAt >= 0 pulls reset low during that cycle.
  // disturb pulses start and changes round to 5 while the sequence is playing.
  task automatic applyStimulus(input int rnd, input int abortAt, input bit disturb);
    int n;
    int s;
    int p;
    logic [3:0] expLed;
    string ctx;
    n = (rnd + 1) * P;
    start = 1'b1;
    round = 4'(rnd);
    tick();
    start = 1'b0;
    for (int t = 0; t <= n + 1; t++) begin
      ctx = $sformatf("r%0d t%0d", rnd, t);
      if (t < n) begin
        s = t / P;
        p = t % P;
        expLed = (p >= 2 && p < 2 + ON) ? rom[s] : 4'd0;
        checkAll(ctx, expLed, 4'(s), 1'b1, 1'b0);
      end else if (t == n) begin
        checkAll(ctx, 4'd0, 4'(rnd), 1'b1, 1'b1);
      end else begin
        checkAll(ctx, 4'd0, 4'(rnd), 1'b0, 1'b0);
      end
      if (t == abortAt) begin
        R = 1'b0;
        tick();
        R = 1'b1;
        checkAll("abort", 4'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
          tick();
          checkAll("postAbort", 4'd0, 4'd0, 1'b0, 1'b0);
        end
        return;
      end
      if (disturb && t == 10) begin
        start = 1'b1;
        round = 4'd5;
      end
      if (disturb && t == 11) start = 1'b0;
      if (t <= n) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    R     = 1'b0;
    start = 1'b1;
    round = 4'd7;

    // Reset is held low with start high. The player must stay dark and idle.
    for (int i = 0; i < 2; i++) begin
      tick();
      checkAll("reset", 4'd0, 4'd0, 1'b0, 1'b0);
    end
    R     = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("idle", 4'd0, 4'd0, 1'b0, 1'b0);
    end

    // Single step.
    rom[0] = 4'b0100;
    applyStimulus(0, -1, 1'b0);

    // Four steps with one-hot codes. These runs are back-to-back.
    rom[0] = 4'b0001;
    rom[1] = 4'b0010;
    rom[2] = 4'b0100;
    rom[3] = 4'b1000;
    applyStimulus(3, -1, 1'b0);
    applyStimulus(3, -1, 1'b1);

    // Reset during SHOW of step 2, then a fresh start from address 0.
    applyStimulus(3, 2 * P + 3, 1'b0);
    applyStimulus(2, -1, 1'b0);

    // Full length with random codes and one dark step, then a back-to-back start.
    $display("[TB] full-length run");
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[5] = 4'd0;
    applyStimulus(15, -1, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(int'($urandom_range(1, 6)), -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Downstream consumer of the round/address stage.
- On a start pulse it walks ROM addresses 0..round and fetches each stored colour code from the sequence ROM.
- It shows each code on the four LEDs for a fixed on-time, then blanks them for a fixed gap.
- When the whole sequence has been shown it pulses done, so the game controller can hand over to player input.

Parameters:
ADDR_W, 4, width of round and rom_addr
DATA_W, 4, width of rom_data and led (one bit per colour)
ON_TICKS, 50, clk cycles each step is lit (legal range 1..1023)
OFF_TICKS, 25, clk cycles of blank gap after each step (legal range 1..1023)

Ports:
clk  input  1  system clock, rising edge
R  input  1  synchronous reset, active-low
start  input  1  one-cycle request to play the sequence; sampled only in IDLE
round  input  ADDR_W  index of the last step to play (plays round+1 steps); latched when start is accepted
rom_addr  output  ADDR_W  registered address to the sequence ROM
rom_data  input  DATA_W  ROM output, valid one cycle after rom_addr changes (synchronous ROM)
led  output  DATA_W  registered LED drive; 0 = all off
busy  output  1  high from the cycle after start is accepted until done drops
done  output  1  one-cycle pulse when the sequence has finished

Behaviour:
- Reset (R==0 at a clk edge): state=IDLE, led=0, rom_addr=0, busy=0, done=0, step index=0, tick counter=0.
  - Reset overrides every other input, including in mid-sequence; the player stops with LEDs dark and no done pulse.
- Interface fixed by decision: one clock; reset is synchronous and active-low.
- States: IDLE, FETCH, WAIT, SHOW, GAP, FIN.
- IDLE: busy=0, led=0.
  - If start==1 at an edge: latch round into round_q, idx=0, rom_addr=0, go to FETCH.
- FETCH: busy=1; rom_addr holds idx; next edge → WAIT. This cycle covers the ROM read latency.
- WAIT: rom_data is valid.
  - Next edge: led<=rom_data, tick counter=0, → SHOW.
- SHOW: led holds the captured code for exactly ON_TICKS cycles.
  - At the edge ending the last cycle: led<=0, counter=0, → GAP.
- GAP: led=0 for exactly OFF_TICKS cycles.
  - At the edge ending the last cycle: if idx==round_q → FIN.
  - Otherwise idx<=idx+1, rom_addr<=idx+1, → FETCH.
- FIN: done=1 and busy=1 for exactly one cycle; next edge → IDLE (busy=0, done=0).
- Per-step period: 2+ON_TICKS+OFF_TICKS cycles.
  - If start is sampled at edge k, done is high during the cycle after edge k+(round+1)*(2+ON_TICKS+OFF_TICKS).
- start outside IDLE is ignored (no restart, no queuing). A start in the IDLE cycle right after FIN is accepted.
- round is only read at acceptance; later changes do not affect the sequence in flight.
- round = 2^ADDR_W−1 plays every address. idx never increments past round_q, so no wrap occurs.
- rom_data == 0 at some address: that step is shown as dark for ON_TICKS; timing is unchanged.
- Tick counter: 10 bits, unsigned. Compare against ON_TICKS−1 / OFF_TICKS−1; no wrap within the legal range.
- led changes only on SHOW entry and SHOW exit (plus reset), so it is glitch-free.

Test Plan (ON_TICKS=3, OFF_TICKS=2, so 7 cycles/step):
- Reset: hold R=0 for 2 cycles with start=1 → led=0, busy=0, done=0, rom_addr=0 throughout; after release with start=0 the block stays IDLE.
- Round 0: ROM[0]=4'b0100; pulse start at edge k with round=0 → busy high after edge k; led=0100 for exactly 3 cycles starting after edge k+2; led=0 for 2 cycles; done high for one cycle after edge k+7; busy low after edge k+8.
- Round 3: ROM = 1,2,4,8; round=3 → rom_addr steps 0,1,2,3 at 7-cycle spacing; led shows 0001, 0010, 0100, 1000 in that order; a single done pulse after edge k+28.
- Ignored start and round change: start pulsed again and round changed to 5 in mid-sequence of the round-3 run → timing and sequence are identical to the previous scenario; exactly one done pulse.
- Mid-run reset: R=0 for one edge while in SHOW of step 2 → the next cycle has led=0, busy=0, rom_addr=0, and done never fires; a new start plays from address 0.
- Full length with back-to-back start: round=15 → 16 steps, rom_addr reaches 15 and done fires after 112 cycles; a start in the IDLE cycle right after done is accepted immediately.
